// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: request record, FSM states, grant ids.
package mem_arbiter_pkg;

  localparam int unsigned REQ_ADDR_W = 32;
  localparam int unsigned REQ_DATA_W = 32;
  localparam int unsigned REQ_STRB_W = REQ_DATA_W / 8;

  typedef struct packed {
    logic                  instr;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
    logic [REQ_STRB_W-1:0] wstrb;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    GRANT_IMEM = 1'b0,
    GRANT_DMEM = 1'b1
  } grant_t;

endpackage

// File: rtl/arb_slot.sv
// One-deep request buffer for one arbiter port. Offers either the held request or the
// live one (bypass) to the arbiter; pulses arriving while full or in flight are dropped.
module arb_slot
  import mem_arbiter_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     req_valid,
  input  mem_req_t req_in,
  input  logic     in_flight,
  input  logic     take,
  output logic     eligible,
  output mem_req_t req_out
);

  logic     full_q;
  mem_req_t slot_q;
  logic     accept;

  assign accept   = req_valid & ~full_q & ~in_flight;
  assign eligible = full_q | accept;
  assign req_out  = full_q ? slot_q : req_in;

  // A take in the same cycle as an accept is a bypass grant, so nothing is stored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      slot_q <= '0;
    end else if (take) begin
      full_q <= 1'b0;
    end else if (accept) begin
      full_q <= 1'b1;
      slot_q <= req_in;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester front end for the single-outstanding bridge: buffers one request per port,
// round-robins on ties and routes each response back to the port that issued it.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                imem_valid,
  input  logic [ADDR_W-1:0]   imem_addr,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_ready,
  input  logic                dmem_valid,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W/8-1:0] dmem_wstrb,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_ready,
  output logic                mem_valid,
  output logic                mem_instr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  arb_state_t state_q;
  grant_t     last_grant_q;

  mem_req_t imem_req, dmem_req;
  mem_req_t imem_sel, dmem_sel, grant_req;
  logic     imem_elig, dmem_elig;
  logic     grant_imem, grant_dmem;
  logic     decide;

  assign imem_req = '{instr: 1'b1, addr: imem_addr, wdata: '0, wstrb: '0};
  assign dmem_req = '{instr: 1'b0, addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb};

  arb_slot u_imem_slot (
    .clock     (clock),
    .reset     (reset),
    .req_valid (imem_valid),
    .req_in    (imem_req),
    .in_flight (state_q == BUSY_I),
    .take      (grant_imem),
    .eligible  (imem_elig),
    .req_out   (imem_sel)
  );

  arb_slot u_dmem_slot (
    .clock     (clock),
    .reset     (reset),
    .req_valid (dmem_valid),
    .req_in    (dmem_req),
    .in_flight (state_q == BUSY_D),
    .take      (grant_dmem),
    .eligible  (dmem_elig),
    .req_out   (dmem_sel)
  );

  // Decisions happen in IDLE or on the bridge's completion; the owning port is blocked
  // then, so a tie can only arise in IDLE.
  always_comb begin
    decide     = (state_q == IDLE) || mem_ready;
    grant_imem = 1'b0;
    grant_dmem = 1'b0;
    if (decide) begin
      if (imem_elig && dmem_elig) begin
        if (last_grant_q == GRANT_IMEM) begin
          grant_dmem = 1'b1;
        end else begin
          grant_imem = 1'b1;
        end
      end else begin
        grant_imem = imem_elig;
        grant_dmem = dmem_elig;
      end
    end
    grant_req = grant_imem ? imem_sel : dmem_sel;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_IMEM;
      mem_valid    <= 1'b0;
      mem_instr    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      imem_ready   <= 1'b0;
      imem_rdata   <= '0;
      dmem_ready   <= 1'b0;
      dmem_rdata   <= '0;
    end else begin
      mem_valid  <= 1'b0;
      imem_ready <= 1'b0;
      imem_rdata <= '0;
      dmem_ready <= 1'b0;
      dmem_rdata <= '0;

      unique case (state_q)
        IDLE: begin
        end
        BUSY_I: begin
          if (mem_ready) begin
            imem_ready <= 1'b1;
            imem_rdata <= mem_rdata;
            state_q    <= IDLE;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            dmem_ready <= 1'b1;
            dmem_rdata <= mem_rdata;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A new grant overrides the return to IDLE above.
      if (grant_imem || grant_dmem) begin
        state_q      <= grant_imem ? BUSY_I : BUSY_D;
        last_grant_q <= grant_imem ? GRANT_IMEM : GRANT_DMEM;
        mem_valid    <= 1'b1;
        mem_instr    <= grant_req.instr;
        mem_addr     <= grant_req.addr;
        mem_wdata    <= grant_req.wdata;
        mem_wstrb    <= grant_req.wstrb;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a latency-programmable single-outstanding bridge model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_addr = '0;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        dmem_valid = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [3:0]  dmem_wstrb = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .dmem_valid (dmem_valid),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  int errors = 0;
  int checks = 0;

  mem_req_t    exp_mem_q[$];
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];

  int n_mem = 0;
  int n_iready = 0;
  int n_dready = 0;
  int gap_hits = 0;
  bit gap_check = 1'b0;
  int lat = 3;
  bit spur_req = 1'b0;
  bit owned_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic mem_req_t mk(input logic instr, input logic [31:0] a,
                                  input logic [31:0] w, input logic [3:0] s);
    mem_req_t r;
    r.instr = instr;
    r.addr  = a;
    r.wdata = w;
    r.wstrb = s;
    return r;
  endfunction

  // Bridge data: fixed word for 0x100, zero for stores, else {addr[15:0], C0DE}.
  function automatic logic [31:0] resp_of(input logic [31:0] a, input logic [3:0] s);
    if (s != 4'h0) return 32'h0;
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return {a[15:0], 16'hC0DE};
  endfunction

  initial begin : bridge
    int          cnt;
    logic [31:0] b_addr;
    logic [3:0]  b_wstrb;
    cnt = 0;
    b_addr = '0;
    b_wstrb = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock);
      #2;
      mem_ready   = 1'b0;
      mem_rdata   = '0;
      owned_ready = 1'b0;
      if (!reset) begin
        cnt = 0;
      end else if (mem_valid) begin
        check("bridge_one_outstanding", 64'(cnt), 64'd0);
        cnt = lat;
        b_addr = mem_addr;
        b_wstrb = mem_wstrb;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_ready   = 1'b1;
          mem_rdata   = resp_of(b_addr, b_wstrb);
          owned_ready = 1'b1;
        end
      end else if (spur_req) begin
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        spur_req  = 1'b0;
      end
    end
  end

  initial begin : monitor
    bit       prev_owned;
    bit       prev_mv;
    bit       prev_ir;
    bit       prev_dr;
    bit       gap_armed;
    int       neg;
    int       armed_neg;
    mem_req_t e;
    prev_owned = 1'b0;
    prev_mv = 1'b0;
    prev_ir = 1'b0;
    prev_dr = 1'b0;
    gap_armed = 1'b0;
    neg = 0;
    armed_neg = 0;
    forever begin
      @(negedge clock);
      neg++;
      if (!gap_check) gap_armed = 1'b0;
      if (!reset) begin
        prev_owned = 1'b0;
        prev_mv = 1'b0;
        prev_ir = 1'b0;
        prev_dr = 1'b0;
        gap_armed = 1'b0;
      end else begin
        if (mem_valid) begin
          n_mem++;
          check("mem_valid_single_cycle", 64'(prev_mv), 64'd0);
          if (gap_armed) begin
            check("issue_gap_after_mem_ready", 64'(neg - armed_neg), 64'd1);
            gap_hits++;
            gap_armed = 1'b0;
          end
          check("mem_request_expected", 64'(exp_mem_q.size() != 0), 64'd1);
          if (exp_mem_q.size() != 0) begin
            e = exp_mem_q.pop_front();
            check("mem_instr", 64'(mem_instr), 64'(e.instr));
            check("mem_addr", 64'(mem_addr), 64'(e.addr));
            check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
            check("mem_wstrb", 64'(mem_wstrb), 64'(e.wstrb));
          end
        end
        check("x_ready_follows_mem_ready", 64'(imem_ready | dmem_ready), 64'(prev_owned));
        check("ready_one_hot", 64'(imem_ready & dmem_ready), 64'd0);
        if (imem_ready) begin
          n_iready++;
          check("imem_ready_single_cycle", 64'(prev_ir), 64'd0);
          check("imem_response_expected", 64'(exp_i_q.size() != 0), 64'd1);
          if (exp_i_q.size() != 0) check("imem_rdata", 64'(imem_rdata), 64'(exp_i_q.pop_front()));
        end else begin
          check("imem_rdata_idle_zero", 64'(imem_rdata), 64'd0);
        end
        if (dmem_ready) begin
          n_dready++;
          check("dmem_ready_single_cycle", 64'(prev_dr), 64'd0);
          check("dmem_response_expected", 64'(exp_d_q.size() != 0), 64'd1);
          if (exp_d_q.size() != 0) check("dmem_rdata", 64'(dmem_rdata), 64'(exp_d_q.pop_front()));
        end else begin
          check("dmem_rdata_idle_zero", 64'(dmem_rdata), 64'd0);
        end
        prev_mv = mem_valid;
        prev_ir = imem_ready;
        prev_dr = dmem_ready;
        prev_owned = owned_ready;
        if (gap_check && owned_ready) begin
          gap_armed = 1'b1;
          armed_neg = neg;
        end
      end
    end
  end

  task automatic check_zero(input string pfx);
    check({pfx, "_mem_valid"}, 64'(mem_valid), 64'd0);
    check({pfx, "_mem_instr"}, 64'(mem_instr), 64'd0);
    check({pfx, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({pfx, "_mem_wstrb"}, 64'(mem_wstrb), 64'd0);
    check({pfx, "_imem_ready"}, 64'(imem_ready), 64'd0);
    check({pfx, "_imem_rdata"}, 64'(imem_rdata), 64'd0);
    check({pfx, "_dmem_ready"}, 64'(dmem_ready), 64'd0);
    check({pfx, "_dmem_rdata"}, 64'(dmem_rdata), 64'd0);
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic do_reset();
    reset = 1'b0;
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
    #1;
    check_zero("reset_state");
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_i(input logic [31:0] a);
    imem_valid = 1'b1;
    imem_addr  = a;
    @(posedge clock);
    #1;
    imem_valid = 1'b0;
  endtask

  task automatic send_d(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    dmem_valid = 1'b1;
    dmem_addr  = a;
    dmem_wdata = w;
    dmem_wstrb = s;
    @(posedge clock);
    #1;
    dmem_valid = 1'b0;
  endtask

  task automatic send_both(input logic [31:0] ia, input logic [31:0] da);
    imem_valid = 1'b1;
    imem_addr  = ia;
    dmem_valid = 1'b1;
    dmem_addr  = da;
    dmem_wdata = '0;
    dmem_wstrb = '0;
    @(posedge clock);
    #1;
    imem_valid = 1'b0;
    dmem_valid = 1'b0;
  endtask

  task automatic wait_ready(input bit dport, input string name);
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if (dport ? dmem_ready : imem_ready) return;
    end
    check(name, 64'd0, 64'd1);
  endtask

  task automatic drain(input string pfx);
    check({pfx, "_mem_q_empty"}, 64'(exp_mem_q.size()), 64'd0);
    check({pfx, "_imem_q_empty"}, 64'(exp_i_q.size()), 64'd0);
    check({pfx, "_dmem_q_empty"}, 64'(exp_d_q.size()), 64'd0);
  endtask

  initial begin : stimulus
    int m0, i0, d0;
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Single fetch, bridge latency 5.
    do_reset();
    lat = 5;
    exp_mem_q.push_back(mk(1'b1, 32'h0000_0100, 32'h0, 4'h0));
    exp_i_q.push_back(32'hDEAD_BEEF);
    imem_valid = 1'b1;
    imem_addr  = 32'h0000_0100;
    @(posedge clock);
    #1;
    imem_valid = 1'b0;
    @(negedge clock);
    check("fetch_issue_latency", 64'(mem_valid), 64'd1);
    idle(12);
    drain("fetch");

    // Store.
    do_reset();
    lat = 3;
    d0 = n_dready;
    exp_mem_q.push_back(mk(1'b0, 32'h2000_0004, 32'h1234_5678, 4'hF));
    exp_d_q.push_back(32'h0);
    send_d(32'h2000_0004, 32'h1234_5678, 4'hF);
    idle(10);
    check("store_dmem_ready_count", 64'(n_dready - d0), 64'd1);
    drain("store");

    // Tie after reset: dmem first, then imem right after the first mem_ready.
    do_reset();
    gap_hits = 0;
    gap_check = 1'b1;
    exp_mem_q.push_back(mk(1'b0, 32'h200, 32'h0, 4'h0));
    exp_mem_q.push_back(mk(1'b1, 32'h100, 32'h0, 4'h0));
    exp_d_q.push_back(32'h0200_C0DE);
    exp_i_q.push_back(32'hDEAD_BEEF);
    send_both(32'h100, 32'h200);
    idle(15);
    check("tie1_gap_hits", 64'(gap_hits), 64'd1);
    gap_check = 1'b0;
    drain("tie1");
    // A lone dmem request leaves last_grant at dmem, so the next tie goes to imem.
    exp_mem_q.push_back(mk(1'b0, 32'h300, 32'h0, 4'h0));
    exp_d_q.push_back(32'h0300_C0DE);
    send_d(32'h300, 32'h0, 4'h0);
    idle(8);
    exp_mem_q.push_back(mk(1'b1, 32'h104, 32'h0, 4'h0));
    exp_mem_q.push_back(mk(1'b0, 32'h204, 32'h0, 4'h0));
    exp_i_q.push_back(32'h0104_C0DE);
    exp_d_q.push_back(32'h0204_C0DE);
    send_both(32'h104, 32'h204);
    idle(15);
    drain("tie2");

    // Streaming, four alternating requests at latency 3.
    do_reset();
    lat = 3;
    gap_hits = 0;
    gap_check = 1'b1;
    m0 = n_mem;
    i0 = n_iready;
    d0 = n_dready;
    exp_mem_q.push_back(mk(1'b0, 32'h400, 32'h0, 4'h0));
    exp_mem_q.push_back(mk(1'b1, 32'h500, 32'h0, 4'h0));
    exp_mem_q.push_back(mk(1'b0, 32'h404, 32'hCAFE_F00D, 4'h3));
    exp_mem_q.push_back(mk(1'b1, 32'h504, 32'h0, 4'h0));
    exp_d_q.push_back(32'h0400_C0DE);
    exp_d_q.push_back(32'h0);
    exp_i_q.push_back(32'h0500_C0DE);
    exp_i_q.push_back(32'h0504_C0DE);
    fork
      begin
        send_i(32'h500);
        wait_ready(1'b0, "stream_wait_imem_ready");
        send_i(32'h504);
      end
      begin
        send_d(32'h400, 32'h0, 4'h0);
        wait_ready(1'b1, "stream_wait_dmem_ready");
        send_d(32'h404, 32'hCAFE_F00D, 4'h3);
      end
    join
    idle(20);
    check("stream_gap_hits", 64'(gap_hits), 64'd3);
    check("stream_mem_count", 64'(n_mem - m0), 64'd4);
    check("stream_imem_ready_count", 64'(n_iready - i0), 64'd2);
    check("stream_dmem_ready_count", 64'(n_dready - d0), 64'd2);
    gap_check = 1'b0;
    drain("stream");

    // Second dmem pulse while dmem is in flight is dropped; then a spurious mem_ready in IDLE.
    do_reset();
    lat = 5;
    m0 = n_mem;
    d0 = n_dready;
    i0 = n_iready;
    exp_mem_q.push_back(mk(1'b0, 32'h600, 32'h0, 4'h0));
    exp_d_q.push_back(32'h0600_C0DE);
    send_d(32'h600, 32'h0, 4'h0);
    idle(2);
    send_d(32'h700, 32'h1111_2222, 4'hF);
    idle(15);
    spur_req = 1'b1;
    idle(6);
    check("violation_mem_count", 64'(n_mem - m0), 64'd1);
    check("violation_dmem_ready_count", 64'(n_dready - d0), 64'd1);
    check("spurious_imem_ready_count", 64'(n_iready - i0), 64'd0);
    drain("violation");

    // Asynchronous reset in the middle of BUSY_D.
    do_reset();
    lat = 5;
    exp_mem_q.push_back(mk(1'b0, 32'h800, 32'hAAAA_5555, 4'h5));
    send_d(32'h800, 32'hAAAA_5555, 4'h5);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    idle(2);
    reset = 1'b1;
    i0 = n_iready;
    d0 = n_dready;
    idle(10);
    check("no_stale_ready", 64'((n_iready - i0) + (n_dready - d0)), 64'd0);
    exp_mem_q.push_back(mk(1'b1, 32'h900, 32'h0, 4'h0));
    exp_i_q.push_back(32'h0900_C0DE);
    send_i(32'h900);
    idle(12);
    check("post_reset_fetch_ready_count", 64'(n_iready - i0), 64'd1);
    drain("async_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
